tone_gen_multi: RTL
===================

# tone_gen_multi

Parametrised square-wave tone generator that turns a one-hot note selection plus an octave index into a PWM-drivable audio square wave. It replaces the fixed three-octave note decoder in the audio path: any number of notes, 2^OCT_W octaves derived by shifting one base table, synchronous reset, and glitch-free pitch changes applied only on half-period boundaries. It sits between the key/sequencer logic and the buzzer pin. The current half-period is exported so the display block can show it.

## Interface
- CLK_HZ, 100_000_000: system clock frequency; documents the table defaults only, not used in arithmetic.
- NOTES, 7: number of one-hot note inputs.
- OCT_W, 2: octave index width; octaves 0..2^OCT_W-1, 0 is lowest.
- DIV_W, 32: half-period counter and table entry width.
- HP_TABLE, packed NOTES*DIV_W bits: octave-0 half-period counts. Entry i is at bits [i*DIV_W +: DIV_W], note index 0 = do. Defaults at 100 MHz (C3..B3): 382234, 340530, 303380, 286352, 255102, 227273, 202478.
- MIN_HP, 2: lower clamp on any effective half-period.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- notes  in  NOTES  one-hot note request. Bit NOTES-1 = index 0 (do), bit 0 = index NOTES-1, matching the existing key ordering. All-zero or multi-hot requests a rest.
- octave  in  OCT_W  octave index.
- pwm  out  1  square-wave output.
- active  out  1  high while a tone is sounding (the counter is running).
- half_period  out  DIV_W  effective half-period currently in force; 0 when silent.

## Operation
- Request decode (combinational): valid when `notes` has exactly one bit set. The selected index is `idx`.
  - `req_hp` = max(HP_TABLE[idx] >> octave, MIN_HP).
  - Invalid request gives `req_hp` = 0 (rest).
- State IDLE:
  - pwm = 0, active = 0, half_period = 0, cnt = 0.
  - On a cycle with `req_hp` != 0: half_period <= req_hp, cnt <= req_hp-1, active <= 1, go to RUN. pwm stays 0.
- State RUN, cnt != 0:
  - cnt <= cnt-1.
  - Request changes are ignored this cycle. They are sampled only at the boundary.
- State RUN, cnt == 0 (the boundary), sample `req_hp`:
  - req_hp == 0: pwm <= 0, active <= 0, half_period <= 0, go to IDLE.
  - Otherwise: pwm <= ~pwm, half_period <= req_hp, cnt <= req_hp-1.
  - A new pitch therefore starts on a clean edge. No runt pulses, no mid-period glitches.
- Output period is 2*half_period clock cycles, duty exactly 50% for a steady request.
- Arithmetic: right-shift is logical. The clamp is applied after the shift. Counter width is DIV_W. No overflow is possible because cnt ≤ req_hp-1.
- Table entries of 0 or 1 are clamped to MIN_HP; they are never treated as a rest.

## Timing
- Reset: the cycle after rst is sampled high gives pwm = 0, active = 0, half_period = 0, cnt = 0, state IDLE.
  - Reset has priority over everything, including mid-period.
  - The first note can start on the cycle after rst deasserts.
- Start latency: request sampled at edge k gives active = 1 and half_period valid after edge k. First pwm rise follows edge k + req_hp.
- Pitch-change latency: at most one current half-period, plus one cycle.
- Stop: a rest takes effect at the next boundary. pwm is forced 0 there even if it was 0 already. In the worst case one full half-period of the old tone still plays.
- Simultaneous rest and boundary in the same cycle: the rest wins, go to IDLE.
- A request that is valid only between boundaries is never heard.

## Test plan
- Reset: hold rst 3 cycles while notes = 7'b1000000.
  - Outputs must be pwm = 0, active = 0, half_period = 0.
  - After release, half_period = 382234 one cycle later, and the first pwm rise 382234 cycles after that.
- Octave scaling: override HP_TABLE entry 0 to 40. notes = 7'b1000000, octave = 0..3.
  - Measured pwm periods must be 80, 40, 20, 10 cycles, duty 50%.
- Clamp: entry 0 = 5, octave = 3 (5>>3 = 0).
  - half_period must equal 2 (MIN_HP) and the pwm period must be 4.
- Glitch-free change: table entries 0 = 20 and 1 = 8. Switch notes from do to re 7 cycles into a half-period.
  - The old level must last the full 20 cycles, then 8-cycle halves.
  - No high or low pulse shorter than 8 cycles.
- Rest handling:
  - Multi-hot notes = 7'b1100000 mid-tone: pwm = 0 and active = 0 exactly at the next boundary.
  - All-zero from IDLE: outputs stay 0.
- Reset mid-tone: assert rst while pwm = 1 with cnt ≠ 0.
  - pwm = 0 next cycle.
  - With the request held, restart follows the Start-latency rule.

Source files
------------

// File: rtl/tone_gen_multi.sv
// tone_gen_multi: square-wave tone generator with one-hot note select and octave shift.
//
// The octave-0 half-period of each note comes from HP_TABLE and is right-shifted by
// the octave index, then clamped to MIN_HP. A pitch change is applied only at a
// half-period boundary, so the output never produces runt pulses.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   notes       in   one-hot note request; MSB is note index 0; zero or multi-hot is a rest
//   octave      in   octave index, 0 is lowest
//   pwm         out  square-wave output
//   active      out  high while a tone is sounding
//   half_period out  half-period currently in force, 0 when silent
module tone_gen_multi #(
  parameter int unsigned              CLK_HZ   = 100_000_000,
  parameter int unsigned              NOTES    = 7,
  parameter int unsigned              OCT_W    = 2,
  parameter int unsigned              DIV_W    = 32,
  parameter logic [NOTES*DIV_W-1:0]   HP_TABLE = {32'd202478, 32'd227273, 32'd255102,
                                                  32'd286352, 32'd303380, 32'd340530,
                                                  32'd382234},
  parameter int unsigned              MIN_HP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NOTES-1:0] notes,
  input  logic [OCT_W-1:0] octave,
  output logic             pwm,
  output logic             active,
  output logic [DIV_W-1:0] half_period
);

  // CLK_HZ only documents the table defaults; a zero value is a configuration error.
  if (CLK_HZ == 0 || MIN_HP == 0) begin : g_param_check
    $error("tone_gen_multi: CLK_HZ and MIN_HP must be non-zero");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] hp_q;
  logic             pwm_q;
  logic             active_q;

  int unsigned      ones;
  int unsigned      sel_bit;
  logic             req_valid;
  logic [DIV_W-1:0] entry;
  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] req_hp;

  // Request decode: exactly one bit set selects a note, anything else is a rest.
  always_comb begin
    ones    = 0;
    sel_bit = 0;
    for (int unsigned i = 0; i < NOTES; i++) begin
      if (notes[i]) begin
        ones    = ones + 1;
        sel_bit = i;
      end
    end
    req_valid = (ones == 1);
    // Bit NOTES-1 is note index 0, so the table index is mirrored.
    entry   = HP_TABLE[(NOTES - 1 - sel_bit) * DIV_W +: DIV_W];
    shifted = entry >> octave;
    if (!req_valid) begin
      req_hp = '0;
    end else if (shifted < DIV_W'(MIN_HP)) begin
      req_hp = DIV_W'(MIN_HP);
    end else begin
      req_hp = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hp_q     <= '0;
      pwm_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_hp != '0) begin
            hp_q     <= req_hp;
            cnt_q    <= req_hp - DIV_W'(1);
            active_q <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
          end else if (req_hp == '0) begin
            // Rest wins over the boundary toggle.
            pwm_q    <= 1'b0;
            active_q <= 1'b0;
            hp_q     <= '0;
            cnt_q    <= '0;
            state_q  <= StIdle;
          end else begin
            pwm_q <= ~pwm_q;
            hp_q  <= req_hp;
            cnt_q <= req_hp - DIV_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pwm         = pwm_q;
  assign active      = active_q;
  assign half_period = hp_q;

endmodule
